fetch_stage: RTL
================

// Module: fetch_stage
// PURPOSE
// - ARM pipeline fetch stage: PC register, PC+4 incrementer, branch redirect and IF/ID pipeline register.
// - Sits upstream of decode and the hazard detection unit.
// - Freezes on the hazard unit's HAZARD output.
// - Flushes on a taken branch resolved in EXE.
// - Instruction memory is external with combinational read: imem_addr out, imem_rdata in, same cycle.
// PARAMETERS
// - RESET_PC   32'h0000_0000  PC value loaded on reset
// - NOP_INSTR  32'h0000_0000  instruction word injected into IF/ID on reset/flush
// - CNT_W      16             width of performance counters (FETCH_PERF_CNT_EN only)
// PORTS
// - clk            in   1   single clock, all state updates on rising edge
// - rst            in   1   asynchronous, active-high reset
// - freeze         in   1   stall from hazard unit; hold PC and IF/ID
// - branch_taken   in   1   EXE-resolved taken branch; redirect PC and flush IF/ID
// - branch_addr    in   32  branch target address
// - imem_addr      out  32  instruction address = current PC (combinational)
// - imem_rdata     in   32  instruction word at imem_addr (combinational)
// - if_id_pc       out  32  registered PC+4 of the fetched instruction
// - if_id_instr    out  32  registered instruction word
// - if_id_valid    out  1   1 = IF/ID holds a real instruction; 0 = bubble
// - stall_cnt      out  CNT_W  cycles with freeze=1 and branch_taken=0 (macro only)
// - flush_cnt      out  CNT_W  cycles with branch_taken=1 (macro only)
// BEHAVIOUR
// - Reset (async, any time, including mid-stall or mid-redirect) sets:
//   - pc = RESET_PC
//   - if_id_pc = 0, if_id_instr = NOP_INSTR, if_id_valid = 0
//   - counters = 0
// - First fetch occurs in the first rising edge after rst deasserts.
// - PC next-state priority, per rising edge:
//   1. branch_taken: pc <= {branch_addr[31:2], 2'b00}
//   2. freeze: pc holds
//   3. otherwise: pc <= pc + 4, modulo 2^32 (32'hFFFF_FFFC wraps to 0)
// - IF/ID next-state priority:
//   1. branch_taken: flush to {0, NOP_INSTR, valid=0}
//   2. freeze: hold all three fields unchanged
//   3. otherwise: load {pc+4, imem_rdata, 1}
// - branch_taken and freeze both high: branch wins; redirect and flush occur, stall is dropped.
// - Latency: one cycle from fetch to IF/ID. The branch target's instruction appears in IF/ID two edges after branch_taken.
// - imem_addr always equals pc; no handshake with memory; imem_rdata is sampled only on a load edge.
// - No internal FSM beyond the PC and IF/ID registers. No X propagation: all registers are reset.
// CONFIGURATION
// - FETCH_PERF_CNT_EN defined:
//   - stall_cnt and flush_cnt ports exist.
//   - Each counter increments by 1 on the edges where it qualifies.
//   - Counters saturate at all-ones; they do not wrap.
//   - Reset clears both counters.
// - FETCH_PERF_CNT_EN undefined: the counter ports and their logic are absent; all other behaviour is identical.
// TESTING
// - Reset, then 4 free cycles, imem returns addr-as-data:
//   - if_id_pc = 4, 8, 12, 16
//   - if_id_instr = 0, 4, 8, 12
//   - if_id_valid = 1 from the 1st edge on
// - freeze=1 for 3 cycles at pc=8: pc stays 8, IF/ID frozen; on release the next load is {12, 8, 1}.
// - branch_taken=1, branch_addr=32'h103 at pc=20:
//   - pc = 32'h100
//   - IF/ID = {0, NOP_INSTR, 0}
//   - next edge: if_id_pc = 32'h104
// - branch_taken=1 and freeze=1 in the same cycle: behaves exactly as a branch alone; no hold.
// - PC wrap: branch to 32'hFFFF_FFFC, then a free cycle gives pc = 0 and if_id_pc = 0.
// - rst pulsed asynchronously mid-freeze (between edges): outputs return to reset values immediately.
// - FETCH_PERF_CNT_EN: 5 freeze cycles and 2 branches give stall_cnt = 5, flush_cnt = 2.
// - FETCH_PERF_CNT_EN: force 2^CNT_W + 3 freeze cycles; stall_cnt holds at all-ones.

Source files
------------

// File: rtl/fetch_stage.sv
// Pipeline fetch stage: PC register, PC+4 incrementer, branch redirect and IF/ID register.
// Optional stall/flush performance counters are enabled by defining FETCH_PERF_CNT_EN.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
`ifdef FETCH_PERF_CNT_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        branch_taken,
  input  logic [31:0] branch_addr,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_instr,
  output logic        if_id_valid
`ifdef FETCH_PERF_CNT_EN
  , output logic [CNT_W-1:0] stall_cnt
  , output logic [CNT_W-1:0] flush_cnt
`endif
);

  logic [31:0] pc;
  logic [31:0] pc_plus4;

  assign pc_plus4  = pc + 32'd4;
  assign imem_addr = pc;

  // Branch outranks freeze: a taken branch always redirects, even while stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= RESET_PC;
    end else if (branch_taken) begin
      pc <= branch_addr & 32'hFFFF_FFFC;
    end else if (!freeze) begin
      pc <= pc_plus4;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_id_pc    <= 32'h0000_0000;
      if_id_instr <= NOP_INSTR;
      if_id_valid <= 1'b0;
    end else if (branch_taken) begin
      if_id_pc    <= 32'h0000_0000;
      if_id_instr <= NOP_INSTR;
      if_id_valid <= 1'b0;
    end else if (!freeze) begin
      if_id_pc    <= pc_plus4;
      if_id_instr <= imem_rdata;
      if_id_valid <= 1'b1;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  // Saturating counters; a cycle with both freeze and branch counts only as a flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (freeze && !branch_taken && (stall_cnt != {CNT_W{1'b1}})) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
      if (branch_taken && (flush_cnt != {CNT_W{1'b1}})) begin
        flush_cnt <= flush_cnt + CNT_W'(1);
      end
    end
  end
`endif

endmodule
